// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 register file / exception controller.
//   - CP0 register addresses used by MTC0/MFC0
//   - ExcCode values the controller cares about
//   - Status/Cause bit positions and the Status reset value
package cp0_pkg;

    // Register addresses (rd field of MTC0/MFC0, select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Status bit positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // Cause bit positions
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;
    localparam int CA_IP_LO   = 8;
    localparam int CA_IP_HI   = 15;
    localparam int CA_HWIP_LO = 10;
    localparam int CA_WP      = 22;
    localparam int CA_IV      = 23;
    localparam int CA_BD      = 31;

    // Cause bits software may write: IP[1:0], WP, IV
    localparam logic [31:0] CAUSE_SW_WMASK = 32'h00C0_0300;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with a clock prescaler and sticky timer flag.
//   clk, rst       : clock, synchronous active-high reset
//   count_we_i     : MTC0 to Count (overrides the increment, restarts prescaler)
//   compare_we_i   : MTC0 to Compare (also clears the timer flag)
//   wdata_i        : MTC0 data
//   count_o        : current Count
//   compare_o      : current Compare
//   timer_int_o    : set the edge after Count==Compare (Compare!=0), held until
//                    Compare is written
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          tint_q, tint_d;
    logic          tick, match;

    always_comb begin
        tick      = (pre_q == PRE_LAST);
        match     = (compare_q != 32'd0) && (count_q == compare_q);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        count_d   = tick ? count_q + 32'd1 : count_q;
        if (count_we_i) begin
            count_d = wdata_i;
            pre_d   = '0;
        end
        compare_d = compare_we_i ? wdata_i : compare_q;
        // A Compare write acknowledges the interrupt even if a match is
        // being seen in the same cycle.
        tint_d    = compare_we_i ? 1'b0 : (tint_q | match);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tint_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            tint_q    <= tint_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_exc_regfile.sv
// cp0_exc_regfile: CP0 register file plus exception/interrupt controller.
//   clk, rst                     : clock, synchronous active-high reset
//   we_i/waddr_i/data_i          : MTC0 write port (write-back stage)
//   raddr_i/data_o               : MFC0 read port (combinational, no bypass)
//   int_i[HW_INT_N]              : level-sensitive external interrupts -> Cause.IP[7:2]
//   exc_valid_i/exc_code_i/exc_pc_i/exc_bd_i : exception commit
//   eret_i                       : ERET commit
//   count_o..epc_o               : live register values
//   timer_int_o                  : sticky timer interrupt
//   int_req_o                    : enabled, unmasked interrupt pending
// Optional: define CP0_BADVADDR_EN to add exc_badvaddr_i and BadVAddr (reg 8).
module cp0_exc_regfile
    import cp0_pkg::*;
#(
    parameter int          HW_INT_N   = 6,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0080_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [4:0]          waddr_i,
    input  logic [4:0]          raddr_i,
    input  logic [31:0]         data_i,
    input  logic [HW_INT_N-1:0] int_i,
    input  logic                exc_valid_i,
    input  logic [4:0]          exc_code_i,
    input  logic [31:0]         exc_pc_i,
    input  logic                exc_bd_i,
    input  logic                eret_i,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]         exc_badvaddr_i,
`endif
    output logic [31:0]         data_o,
    output logic [31:0]         count_o,
    output logic [31:0]         compare_o,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic                timer_int_o,
    output logic                int_req_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] prid_q, config_q;
    logic [5:0]  int_pad;
    logic        count_we, compare_we;
    logic [31:0] count, compare;
    logic        timer_int;
    logic [31:0] rdata;

    // Count/Compare writes are never blocked by exception or ERET.
    assign count_we   = we_i && (waddr_i == CP0_COUNT);
    assign compare_we = we_i && (waddr_i == CP0_COMPARE);

    cp0_timer #(
        .COUNT_DIV   (COUNT_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_we_i  (count_we),
        .compare_we_i(compare_we),
        .wdata_i     (data_i),
        .count_o     (count),
        .compare_o   (compare),
        .timer_int_o (timer_int)
    );

    always_comb begin
        // Pad external lines to six so unused IP bits fall out as zero.
        int_pad                 = '0;
        int_pad[HW_INT_N-1:0]   = int_i;

        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;

        // IP[7:2] sampled every cycle; IP7 is shared with the timer.
        cause_d[CA_IP_HI:CA_HWIP_LO] = {int_pad[5] | timer_int, int_pad[4:0]};

        if (exc_valid_i) begin
            // Nested exception (EXL already set) keeps the original EPC/BD.
            if (!status_q[ST_EXL]) begin
                epc_d          = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                cause_d[CA_BD] = exc_bd_i;
            end
            cause_d[CA_EXC_HI:CA_EXC_LO] = exc_code_i;
            status_d[ST_EXL]             = 1'b1;
        end else if (eret_i) begin
            status_d[ST_EXL] = 1'b0;
        end else if (we_i) begin
            case (waddr_i)
                CP0_STATUS: status_d = data_i;
                CP0_EPC:    epc_d    = data_i;
                CP0_CAUSE:  cause_d  = (cause_d & ~CAUSE_SW_WMASK) | (data_i & CAUSE_SW_WMASK);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RST;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
            prid_q   <= PRID_VAL;
            config_q <= CONFIG_VAL;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;

    // Captured on address-error exceptions even when nested.
    always_comb begin
        badvaddr_d = badvaddr_q;
        if (exc_valid_i && ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)))
            badvaddr_d = exc_badvaddr_i;
    end

    always_ff @(posedge clk) begin
        if (rst) badvaddr_q <= 32'd0;
        else     badvaddr_q <= badvaddr_d;
    end
`endif

    always_comb begin
        rdata = 32'd0;
        if (!rst) begin
            case (raddr_i)
                CP0_COUNT:    rdata = count;
                CP0_COMPARE:  rdata = compare;
                CP0_STATUS:   rdata = status_q;
                CP0_CAUSE:    rdata = cause_q;
                CP0_EPC:      rdata = epc_q;
                CP0_PRID:     rdata = prid_q;
                CP0_CONFIG:   rdata = config_q;
`ifdef CP0_BADVADDR_EN
                CP0_BADVADDR: rdata = badvaddr_q;
`endif
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign data_o      = rdata;
    assign count_o     = count;
    assign compare_o   = compare;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int;
    assign int_req_o   = !rst && status_q[ST_IE] && !status_q[ST_EXL] &&
                         (|(cause_q[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));

endmodule
